chroni_vram_arbiter: RTL

- Single-port VRAM arbiter directly upstream of the chroni video fetcher.
- Serves chroni's text/font reads over its addr/rd_req/rd_ack/data handshake, and serves CPU reads/writes on a second port.
- Drives one synchronous-read VRAM with fixed read latency.
- Video has strict priority, because chroni must finish 80 text reads plus 80 font reads per scanline pair.

---
 rtl/chroni_vram_pkg.sv | 22 ++
 rtl/chroni_vram_lat_pipe.sv | 55 +++++
 rtl/chroni_vram_arbiter.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/chroni_vram_pkg.sv
// Shared types and constants for the chroni VRAM arbiter.
//
// Contents:
//   arb_state_t  - arbiter FSM state encoding
//   PORT_VID/CPU - requester ids carried through the read-latency pipe
//   DEF_ADDR_W / DEF_DATA_W - default VRAM geometry (matches chroni addr_out)
package chroni_vram_pkg;

    localparam int DEF_ADDR_W = 13;
    localparam int DEF_DATA_W = 8;

    localparam logic PORT_VID = 1'b0;
    localparam logic PORT_CPU = 1'b1;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_ACK   = 2'd3
    } arb_state_t;

endpackage

// File: rtl/chroni_vram_lat_pipe.sv
// Read-latency tracker for the VRAM arbiter.
//
// A DEPTH-deep shift register of (valid, port id). A read is pushed on the
// edge that ends its ISSUE cycle; it reaches the last stage exactly in the
// cycle where VRAM read data is valid, so that stage is the capture strobe.
//
// Ports:
//   sys_clk, reset_n  - clock, asynchronous active-low reset
//   push, push_port   - enqueue a read for the given requester
//   near_valid        - the read will be in the capture stage next cycle
//   cap_valid         - capture mem_rd_data at the coming edge
//   cap_port          - requester that owns the captured data
module chroni_vram_lat_pipe #(
    parameter int DEPTH = 2
) (
    input  logic sys_clk,
    input  logic reset_n,
    input  logic push,
    input  logic push_port,
    output logic near_valid,
    output logic cap_valid,
    output logic cap_port
);

    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] pid;

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            vld <= '0;
            pid <= '0;
        end else begin
            vld[0] <= push;
            pid[0] <= push_port;
            for (int i = 1; i < DEPTH; i++) begin
                vld[i] <= vld[i-1];
                pid[i] <= pid[i-1];
            end
        end
    end

    assign cap_valid = vld[DEPTH-1];
    assign cap_port  = pid[DEPTH-1];

    // With a single stage there is no "one cycle before capture" stage; the
    // arbiter goes straight from ISSUE to ACK in that case.
    generate
        if (DEPTH > 1) begin : g_near
            assign near_valid = vld[DEPTH-2];
        end else begin : g_no_near
            assign near_valid = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/chroni_vram_arbiter.sv
// Single-port VRAM arbiter in front of the chroni video fetcher.
//
// Video reads have strict priority over CPU reads/writes. One access is in
// flight at a time: IDLE (arbitrate) -> ISSUE (one-cycle strobe) -> for reads
// WAIT/ACK while the latency pipe runs -> IDLE. Acks are registered pulses.
// A per-port block flag, set at ack and cleared once that port's request is
// seen low, stops a still-high request from being served twice.
//
// Optional build macro: CHRONI_VRAM_ARB_STARVE_GUARD_EN
//   When defined, after CPU_STARVE_LIMIT video grants made while the CPU was
//   eligible, the CPU wins the next contested arbitration.
//
// Ports:
//   sys_clk, reset_n                      - clock, async active-low reset
//   vid_addr, vid_rd_req                  - video read request
//   vid_rd_ack, vid_data                  - video ack pulse, held read data
//   cpu_addr, cpu_req, cpu_we, cpu_wr_data - CPU request
//   cpu_ack, cpu_rd_data                  - CPU ack pulse, held read data
//   mem_addr, mem_rd_en, mem_wr_en, mem_wr_data, mem_rd_data - VRAM side
//   busy                                  - arbiter not IDLE
module chroni_vram_arbiter
    import chroni_vram_pkg::*;
#(
    parameter int ADDR_W           = DEF_ADDR_W,
    parameter int DATA_W           = DEF_DATA_W,
    parameter int MEM_LATENCY      = 2,
    parameter int CPU_STARVE_LIMIT = 4
) (
    input  logic              sys_clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] vid_addr,
    input  logic              vid_rd_req,
    output logic              vid_rd_ack,
    output logic [DATA_W-1:0] vid_data,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [DATA_W-1:0] cpu_wr_data,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rd_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              busy
);

    arb_state_t        state;
    arb_state_t        next_state;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              lat_we;
    logic              lat_port;
    logic              vid_blk;
    logic              cpu_blk;
    logic              vid_elig;
    logic              cpu_elig;
    logic              force_cpu;
    logic              grant_vid;
    logic              grant_cpu;
    logic              pipe_push;
    logic              pipe_near;
    logic              cap_valid;
    logic              cap_port;
    logic              ack_vid_next;
    logic              ack_cpu_next;

    assign vid_elig = vid_rd_req & ~vid_blk;
    assign cpu_elig = cpu_req & ~cpu_blk;

`ifdef CHRONI_VRAM_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(CPU_STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(CPU_STARVE_LIMIT);
    logic [CNT_W-1:0] starve_cnt;

    assign force_cpu = (starve_cnt == CNT_LIMIT) & vid_elig & cpu_elig;

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= '0;
        end else if (grant_cpu) begin
            starve_cnt <= '0;
        end else if (grant_vid && cpu_elig && starve_cnt != CNT_LIMIT) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    assign force_cpu = 1'b0;
`endif

    assign grant_vid = (state == ARB_IDLE) & vid_elig & ~force_cpu;
    assign grant_cpu = (state == ARB_IDLE) & cpu_elig & (~vid_elig | force_cpu);

    // Only reads enter the latency pipe; writes complete at the end of ISSUE.
    assign pipe_push = (state == ARB_ISSUE) & ~lat_we;

    chroni_vram_lat_pipe #(
        .DEPTH(MEM_LATENCY)
    ) u_lat_pipe (
        .sys_clk   (sys_clk),
        .reset_n   (reset_n),
        .push      (pipe_push),
        .push_port (lat_port),
        .near_valid(pipe_near),
        .cap_valid (cap_valid),
        .cap_port  (cap_port)
    );

    assign ack_vid_next = cap_valid & (cap_port == PORT_VID);
    assign ack_cpu_next = (cap_valid & (cap_port == PORT_CPU)) |
                          ((state == ARB_ISSUE) & lat_we);

    // State register
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ARB_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            ARB_IDLE: begin
                if (grant_vid || grant_cpu) next_state = ARB_ISSUE;
            end
            ARB_ISSUE: begin
                if (lat_we)                next_state = ARB_IDLE;
                else if (MEM_LATENCY == 1) next_state = ARB_ACK;
                else                       next_state = ARB_WAIT;
            end
            ARB_WAIT: begin
                if (pipe_near) next_state = ARB_ACK;
            end
            ARB_ACK: begin
                next_state = ARB_IDLE;
            end
            default: next_state = ARB_IDLE;
        endcase
    end

    // Output logic: decoded only from registered state, no input feed-through
    always_comb begin
        mem_rd_en   = (state == ARB_ISSUE) & ~lat_we;
        mem_wr_en   = (state == ARB_ISSUE) & lat_we;
        mem_addr    = lat_addr;
        mem_wr_data = lat_wdata;
        busy        = (state != ARB_IDLE);
    end

    // Grant latch, ack pulses, held read data and block flags
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            lat_addr    <= '0;
            lat_wdata   <= '0;
            lat_we      <= 1'b0;
            lat_port    <= PORT_VID;
            vid_rd_ack  <= 1'b0;
            cpu_ack     <= 1'b0;
            vid_data    <= '0;
            cpu_rd_data <= '0;
            vid_blk     <= 1'b0;
            cpu_blk     <= 1'b0;
        end else begin
            if (grant_vid) begin
                lat_addr <= vid_addr;
                lat_we   <= 1'b0;
                lat_port <= PORT_VID;
            end else if (grant_cpu) begin
                lat_addr  <= cpu_addr;
                lat_we    <= cpu_we;
                lat_wdata <= cpu_wr_data;
                lat_port  <= PORT_CPU;
            end

            vid_rd_ack <= ack_vid_next;
            cpu_ack    <= ack_cpu_next;
            if (ack_vid_next) vid_data <= mem_rd_data;
            if (cap_valid && cap_port == PORT_CPU) cpu_rd_data <= mem_rd_data;

            // Setting at ack wins over clearing on a low request.
            if (ack_vid_next)     vid_blk <= 1'b1;
            else if (!vid_rd_req) vid_blk <= 1'b0;
            if (ack_cpu_next)     cpu_blk <= 1'b1;
            else if (!cpu_req)    cpu_blk <= 1'b0;
        end
    end

endmodule
